// File: rtl/ddr_wr_pkg.sv
// Shared definitions for the DDR write-path arbiter: FIFO widths, beat count,
// grant index type and arbiter state encoding.
package ddr_wr_pkg;

    localparam int DDR_AW          = 31;
    localparam int DDR_DW          = 128;
    localparam int DDR_MW          = DDR_DW / 8;
    localparam int BEATS_PER_WRITE = 2;
    localparam int BEAT_W          = 1;
    localparam int ID_W            = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/ddr_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, searching
// upward with wrap. Kept generic so the read-side arbiter can reuse it.
module rr_arbiter
    import ddr_wr_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  req_id_t      ptr,
    output req_id_t      gnt_id,
    output logic         gnt_valid
);

    // Distance k from the pointer sets priority; the first hit wins.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_valid && req[i] && (((i - int'(ptr)) + N) % N) == k) begin
                    gnt_valid = 1'b1;
                    gnt_id    = req_id_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Shares the DDR address/write-data FIFO pair among NREQ engines, one 2-beat
// write at a time. Losing engines see both FIFOs full and stall on their own.
module ddr_wr_arbiter
    import ddr_wr_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DDR_AW,
    parameter int DW   = DDR_DW,
    parameter int MW   = DDR_MW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_af_wr_en,
    input  logic [NREQ*AW-1:0] req_af_addr,
    input  logic [NREQ-1:0]    req_wdf_wr_en,
    input  logic [NREQ*DW-1:0] req_wdf_din,
    input  logic [NREQ*MW-1:0] req_wdf_mask,
    output logic [NREQ-1:0]    req_af_full,
    output logic [NREQ-1:0]    req_wdf_full,
    input  logic               af_full,
    input  logic               wdf_full,
    output logic [AW-1:0]      af_addr_din,
    output logic               af_wr_en,
    output logic [DW-1:0]      wdf_din,
    output logic [MW-1:0]      wdf_mask_din,
    output logic               wdf_wr_en,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_WRITE - 1);
    localparam req_id_t           LAST_ID   = req_id_t'(NREQ - 1);

    arb_state_e        state, state_nxt;
    req_id_t           gnt_q, gnt_nxt;
    req_id_t           rr_ptr, rr_ptr_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    req_id_t           arb_id;
    logic              arb_valid;
    logic              sel_af_req, sel_wdf_req;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req       (req_af_wr_en),
        .ptr       (rr_ptr),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            gnt_q  <= '0;
            rr_ptr <= '0;
            beat   <= '0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
            beat   <= beat_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt_q;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = arb_id;
                    beat_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (wdf_wr_en) begin
                    if (beat == LAST_BEAT) begin
                        state_nxt  = ST_IDLE;
                        beat_nxt   = '0;
                        rr_ptr_nxt = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset forces the idle view even while the grant flop still holds GRANT.
    always_comb begin
        req_af_full  = '1;
        req_wdf_full = '1;
        af_addr_din  = '0;
        wdf_din      = '0;
        wdf_mask_din = '1;
        sel_af_req   = 1'b0;
        sel_wdf_req  = 1'b0;
        if (state == ST_GRANT && !rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q == req_id_t'(i)) begin
                    req_af_full[i]  = af_full;
                    req_wdf_full[i] = wdf_full;
                    af_addr_din     = req_af_addr[i*AW +: AW];
                    wdf_din         = req_wdf_din[i*DW +: DW];
                    wdf_mask_din    = req_wdf_mask[i*MW +: MW];
                    sel_af_req      = req_af_wr_en[i];
                    sel_wdf_req     = req_wdf_wr_en[i];
                end
            end
        end
        wdf_wr_en = sel_wdf_req & ~wdf_full & ~af_full;
        af_wr_en  = wdf_wr_en & (beat == '0) & sel_af_req;
    end

    assign busy     = (state == ST_GRANT);
    assign grant_id = gnt_q;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter: behavioural engines, a round-robin
// reference model and a downstream write scoreboard.
module tb_ddr_wr_arbiter;
    import ddr_wr_pkg::*;

    localparam int N  = 3;
    localparam int AW = DDR_AW;
    localparam int DW = DDR_DW;
    localparam int MW = DDR_MW;

    logic            clk, rst;
    logic [N-1:0]    req_af_wr_en, req_wdf_wr_en, req_af_full, req_wdf_full;
    logic [N*AW-1:0] req_af_addr;
    logic [N*DW-1:0] req_wdf_din;
    logic [N*MW-1:0] req_wdf_mask;
    logic            af_full, wdf_full, af_wr_en, wdf_wr_en, busy;
    logic [AW-1:0]   af_addr_din;
    logic [DW-1:0]   wdf_din;
    logic [MW-1:0]   wdf_mask_din;
    logic [1:0]      grant_id;

    ddr_wr_arbiter #(.NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_af_wr_en(req_af_wr_en), .req_af_addr(req_af_addr),
        .req_wdf_wr_en(req_wdf_wr_en), .req_wdf_din(req_wdf_din),
        .req_wdf_mask(req_wdf_mask), .req_af_full(req_af_full),
        .req_wdf_full(req_wdf_full), .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
        .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .busy(busy),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          af;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [MW-1:0] mask;
    } exp_t;

    typedef struct {
        int            eng;
        logic [AW-1:0] addr;
        logic [DW-1:0] d0, d1;
        logic [MW-1:0] m0, m1;
        int            af_stall, wdf_stall, exp_cycles, exp_ptr;
    } vec_t;

    exp_t sb[$];
    int   gseq[$];
    int   n_checks = 0, n_fail = 0, n_af = 0, n_wdf = 0, n_comp = 0;

    // Engine models
    logic          e_act[N], e_beat[N];
    logic [AW-1:0] e_addr[N];
    logic [DW-1:0] e_d[N][2];
    logic [MW-1:0] e_m[N][2];
    int            e_reload[N];

    // Reference arbiter model
    logic m_busy = 1'b0;
    int   m_g = 0, m_ptr = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_af_wr_en[i]           = e_act[i] && !e_beat[i];
            req_wdf_wr_en[i]          = e_act[i];
            req_af_addr[i*AW +: AW]   = e_act[i] ? e_addr[i] : '0;
            req_wdf_din[i*DW +: DW]   = e_act[i] ? e_d[i][e_beat[i]] : '0;
            req_wdf_mask[i*MW +: MW]  = e_act[i] ? e_m[i][e_beat[i]] : '0;
        end
    endtask

    task automatic start_txn(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d0,
                             input logic [DW-1:0] d1, input logic [MW-1:0] m0, input logic [MW-1:0] m1);
        e_act[i] = 1'b1; e_beat[i] = 1'b0; e_addr[i] = a;
        e_d[i][0] = d0; e_d[i][1] = d1; e_m[i][0] = m0; e_m[i][1] = m1;
    endtask

    task automatic start_rand(input int i);
        start_txn(i, AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, MW'($urandom), MW'($urandom));
    endtask

    // One clock: compare at negedge, then advance model and engines after posedge.
    task automatic step();
        logic [N-1:0] acc, exp_acc, exp_faf, exp_fwdf;
        logic         exp_wdf, exp_af, nb;
        int           ng, np;
        exp_t         r;
        @(negedge clk);
        exp_wdf  = !rst && m_busy && e_act[m_g] && !af_full && !wdf_full;
        exp_af   = exp_wdf && !e_beat[m_g];
        exp_faf  = '1;
        exp_fwdf = '1;
        if (!rst && m_busy) begin
            exp_faf[m_g]  = af_full;
            exp_fwdf[m_g] = wdf_full;
        end
        check("busy", busy, m_busy);
        if (m_busy) check("grant_id", grant_id, m_g);
        check("rr_ptr", dut.rr_ptr, m_ptr);
        check("req_af_full", req_af_full, exp_faf);
        check("req_wdf_full", req_wdf_full, exp_fwdf);
        check("wdf_wr_en", wdf_wr_en, exp_wdf);
        check("af_wr_en", af_wr_en, exp_af);
        if (exp_wdf) sb.push_back('{exp_af, e_addr[m_g], e_d[m_g][e_beat[m_g]], e_m[m_g][e_beat[m_g]]});
        if (wdf_wr_en) begin
            if (sb.size() == 0) begin
                check("sb_has_entry", sb.size(), 1);
            end else begin
                r = sb.pop_front();
                check("wdf_din", wdf_din, r.din);
                check("wdf_mask_din", wdf_mask_din, r.mask);
                if (r.af) check("af_addr_din", af_addr_din, r.addr);
            end
        end
        if (!m_busy || rst) begin
            check("idle_addr", af_addr_din, 0);
            check("idle_din", wdf_din, 0);
            check("idle_mask", wdf_mask_din, {MW{1'b1}});
        end
        for (int i = 0; i < N; i++) acc[i] = e_act[i] && !req_af_full[i] && !req_wdf_full[i];
        exp_acc = exp_wdf ? (N'(1) << m_g) : '0;
        check("engine_accept", acc, exp_acc);
        n_af  += int'(af_wr_en);
        n_wdf += int'(wdf_wr_en);
        nb = m_busy; ng = m_g; np = m_ptr;
        if (rst) begin
            nb = 1'b0; ng = 0; np = 0;
        end else if (!m_busy) begin
            if (|req_af_wr_en) begin
                nb = 1'b1;
                ng = rr_pick(req_af_wr_en, m_ptr);
                gseq.push_back(ng);
            end
        end else if (exp_wdf && e_beat[m_g]) begin
            nb = 1'b0;
            np = (m_g + 1) % N;
            n_comp++;
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_g = ng; m_ptr = np;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                e_act[i] = 1'b0;
            end else if (acc[i]) begin
                if (!e_beat[i]) begin
                    e_beat[i] = 1'b1;
                end else begin
                    e_act[i] = 1'b0;
                    if (e_reload[i] > 0) begin
                        e_reload[i]--;
                        start_rand(i);
                    end
                end
            end
        end
        drive();
    endtask

    function automatic logic all_idle();
        logic any = 1'b0;
        for (int i = 0; i < N; i++) any |= e_act[i];
        return !any && !m_busy;
    endfunction

    task automatic run_until_idle(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!all_idle() && cyc < budget) begin
            step();
            cyc++;
        end
        check({name, "_done"}, all_idle(), 1);
    endtask

    task automatic sync_reset();
        for (int i = 0; i < N; i++) begin
            e_act[i] = 1'b0; e_reload[i] = 0;
        end
        drive();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    vec_t vecs[4];
    int   cyc, af0, wdf0, afl, wfl, c0;

    initial begin
        vecs[0] = '{eng: 0, addr: 31'h0001_2340, d0: 128'h0123_4567_89ab_cdef_0011_2233_4455_6677,
                    d1: 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff, m0: 16'h0FFF, m1: 16'hFFFF,
                    af_stall: 0, wdf_stall: 0, exp_cycles: 3, exp_ptr: 1};
        vecs[1] = '{eng: 1, addr: 31'h7FFF_FFF0, d0: 128'h1, d1: 128'h2, m0: 16'h0000, m1: 16'h8001,
                    af_stall: 0, wdf_stall: 5, exp_cycles: 8, exp_ptr: 2};
        vecs[2] = '{eng: 2, addr: 31'h0000_0040, d0: {4{32'hdead_beef}}, d1: {4{32'hcafe_f00d}},
                    m0: 16'h00FF, m1: 16'hFF00, af_stall: 4, wdf_stall: 0, exp_cycles: 7, exp_ptr: 0};
        vecs[3] = '{eng: 1, addr: 31'h5555_5555, d0: {8{16'ha5a5}}, d1: {8{16'h5a5a}},
                    m0: 16'h1234, m1: 16'h4321, af_stall: 2, wdf_stall: 3, exp_cycles: 8, exp_ptr: 2};

        for (int i = 0; i < N; i++) begin
            e_act[i] = 1'b0; e_beat[i] = 1'b0; e_reload[i] = 0;
        end
        drive();
        af_full = 1'b0; wdf_full = 1'b0;

        // Reset state, sampled while rst is still held
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_rr_ptr", dut.rr_ptr, 0);
        check("rst_req_af_full", req_af_full, {N{1'b1}});
        check("rst_req_wdf_full", req_wdf_full, {N{1'b1}});
        check("rst_af_wr_en", af_wr_en, 0);
        check("rst_wdf_wr_en", wdf_wr_en, 0);
        rst = 1'b0;

        // Single transactions with FIFO stalls
        for (int v = 0; v < 4; v++) begin
            af0 = n_af; wdf0 = n_wdf;
            start_txn(vecs[v].eng, vecs[v].addr, vecs[v].d0, vecs[v].d1, vecs[v].m0, vecs[v].m1);
            drive();
            afl = vecs[v].af_stall; wfl = vecs[v].wdf_stall; cyc = 0;
            while (!all_idle() && cyc < 40) begin
                af_full  = m_busy && (afl > 0);
                if (af_full) afl--;
                wdf_full = m_busy && e_beat[vecs[v].eng] && (wfl > 0);
                if (wdf_full) wfl--;
                step();
                cyc++;
            end
            af_full = 1'b0; wdf_full = 1'b0;
            check("vec_done", all_idle(), 1);
            check("vec_cycles", cyc, vecs[v].exp_cycles);
            check("vec_ptr", dut.rr_ptr, vecs[v].exp_ptr);
            check("vec_af_count", n_af - af0, 1);
            check("vec_wdf_count", n_wdf - wdf0, 2);
        end

        // Engines 0 and 1 together; engine 0 keeps requesting
        sync_reset();
        gseq.delete();
        start_rand(0); start_rand(1); e_reload[0] = 1;
        drive();
        run_until_idle("pair", 40, cyc);
        check("pair_grants", gseq.size(), 3);
        if (gseq.size() == 3) begin
            check("pair_g0", gseq[0], 0);
            check("pair_g1", gseq[1], 1);
            check("pair_g2", gseq[2], 0);
        end
        check("pair_cycles", cyc, 9);

        // Reset after beat 0 abandons the transaction
        start_rand(2);
        drive();
        step(); step();
        check("pre_rst_beat", e_beat[2], 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_busy", busy, 0);
        check("post_rst_ptr", dut.rr_ptr, 0);
        check("post_rst_af_full", req_af_full, {N{1'b1}});
        check("post_rst_wdf_full", req_wdf_full, {N{1'b1}});
        check("post_rst_wdf_en", wdf_wr_en, 0);
        start_rand(1);
        drive();
        run_until_idle("after_rst", 20, cyc);
        check("after_rst_ptr", dut.rr_ptr, 2);

        // All engines requesting continuously
        sync_reset();
        gseq.delete();
        af0 = n_af; wdf0 = n_wdf; c0 = n_comp;
        for (int i = 0; i < N; i++) begin
            start_rand(i);
            e_reload[i] = 100;
        end
        drive();
        repeat (30) step();
        for (int i = 0; i < N; i++) e_reload[i] = 0;
        run_until_idle("cont", 40, cyc);
        check("cont_grants", gseq.size() >= 10, 1);
        check("cont_grant_vs_comp", gseq.size(), n_comp - c0);
        for (int k = 0; k < gseq.size(); k++) check("cont_order", gseq[k], k % N);
        check("cont_af_count", n_af - af0, n_comp - c0);
        check("cont_wdf_count", n_wdf - wdf0, 2 * (n_comp - c0));
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_wr_arbiter.md
Name: ddr_wr_arbiter

Overview:
- Shares the single DDR write path (address FIFO plus write-data FIFO) between NREQ graphics write engines, e.g. the line engine and a rectangle-fill engine.
- Each engine issues 2-beat writes: one address plus two 128-bit data beats, with the address presented alongside beat 0.
- The arbiter grants one engine at a time, round-robin, and holds the grant until that engine's second data beat is accepted.
- Non-granted engines see both FIFOs as full, so their normal full-gated write logic stalls them transparently.

Parameters:
- NREQ, 2, number of requesting engines (2..4)
- AW, 31, address FIFO data width
- DW, 128, write-data width
- MW, 16, write-mask width (DW/8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_af_wr_en  in  NREQ  per-engine address write request (bit i = engine i)
- req_af_addr  in  NREQ*AW  flattened per-engine address; engine i at [i*AW +: AW]
- req_wdf_wr_en  in  NREQ  per-engine data-beat write enable
- req_wdf_din  in  NREQ*DW  flattened per-engine write data
- req_wdf_mask  in  NREQ*MW  flattened per-engine byte mask (1 = masked)
- req_af_full  out  NREQ  per-engine view of address FIFO full
- req_wdf_full  out  NREQ  per-engine view of data FIFO full
- af_full  in  1  downstream address FIFO full
- wdf_full  in  1  downstream data FIFO full
- af_addr_din  out  AW  to address FIFO
- af_wr_en  out  1  to address FIFO
- wdf_din  out  DW  to data FIFO
- wdf_mask_din  out  MW  to data FIFO
- wdf_wr_en  out  1  to data FIFO
- busy  out  1  grant active
- grant_id  out  2  index of the granted engine; valid when busy

Behaviour:
- FSM states:
  - IDLE: no grant.
  - GRANT: grant held to engine g.
- Request: engine i is requesting when req_af_wr_en[i]=1. Engines hold af_wr_en high while waiting.
- IDLE -> GRANT:
  - Taken in the cycle any request is high. Grant is registered and effective the next cycle.
  - g = first requester at or after rr_ptr, searching upward with wrap.
  - beat <= 0.
- While in IDLE, every req_*_full output is 1 and every downstream enable is 0.
- In GRANT:
  - req_af_full[g] = af_full and req_wdf_full[g] = wdf_full. All other engines see 1/1.
  - Outputs are driven combinationally from engine g: af_addr_din, wdf_din, wdf_mask_din.
  - wdf_wr_en = req_wdf_wr_en[g] & !wdf_full & !af_full.
  - af_wr_en = wdf_wr_en & (beat==0) & req_af_wr_en[g]. The address is written only together with beat 0.
  - Each cycle with wdf_wr_en=1 increments beat.
  - When beat==1 and wdf_wr_en=1: go to IDLE, rr_ptr <= (g+1) mod NREQ.
- Stalls: either FIFO full means no enable and beat holds. No timeout; the grant is held indefinitely.
- Beat 0 with req_af_wr_en[g]=0 (protocol error): the data beat is still written, the address is not.
- Latency:
  - 1 cycle from request to grant.
  - Minimum 3 cycles per transaction (grant, beat0, beat1), then 1 IDLE cycle.
  - Back-to-back single requester: 1 transaction per 3 cycles.
- Simultaneous requests: strict round-robin. The just-served engine has the lowest priority next.
- Reset: state=IDLE, rr_ptr=0, beat=0, busy=0, grant_id=0.
  - All enables are 0 and all req_*_full are 1 during reset.
  - Reset mid-transaction abandons it. The team accepts a possible orphan beat in the downstream FIFO.
- Outputs in IDLE: af_addr_din, wdf_din, wdf_mask_din = 0 and mask = all ones (all masked).

Decomposition:
- Shared package/header ddr_wr_pkg holds:
  - state encodings (ST_IDLE, ST_GRANT)
  - BEATS_PER_WRITE=2
  - DDR FIFO widths (AW, DW, MW)
- One natural sub-module: rr_arbiter. It is combinational: req vector plus pointer in, one-hot/index grant out. It is reusable for a later read-side arbiter.

Test Plan:
- Single engine 0 request, FIFOs empty, addr 0x0001_2340, two beats mask 0x0FFF/0xFFFF -> grant next cycle, af_wr_en one pulse with addr 0x0001_2340 on beat 0, two wdf_wr_en pulses in consecutive cycles, busy falls, rr_ptr=1.
- Engines 0 and 1 request same cycle after reset -> engine 0 served first, engine 1 sees req_wdf_full=1 throughout, then engine 1 served, then engine 0 again if still requesting.
- wdf_full=1 during granted beat 1 for 5 cycles -> no enables, beat stays 1, grant held, transaction completes the cycle after wdf_full drops.
- af_full=1 at grant -> no af/wdf write until it clears, then address and beat 0 write together in the same cycle.
- rst asserted after beat 0 -> next cycle busy=0, all enables 0, req_*_full all 1, rr_ptr=0; a new request is granted normally.
- Continuous requests on all NREQ=3 engines for 30 cycles -> grants cycle 0,1,2,0,... with exactly 2 data beats and 1 address per grant.
